// File: rtl/dsa_pkg.sv
// Shared types for the bilinear pixel engine: FSM states, per-pixel source
// coordinates and the fixed-point scale helper.
package dsa_pkg;

    localparam int PIX_W_DEF     = 8;
    localparam int FRAC_BITS_DEF = 8;
    localparam int COORD_W       = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CALC,
        S_RD00,
        S_RD10,
        S_RD01,
        S_RD11,
        S_WAIT,
        S_INTERP,
        S_WRITE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0]       x0;
        logic [COORD_W-1:0]       x1;
        logic [COORD_W-1:0]       y0;
        logic [COORD_W-1:0]       y1;
        logic [FRAC_BITS_DEF-1:0] fx;
        logic [FRAC_BITS_DEF-1:0] fy;
    } coord_t;

    // Floored source step per destination pixel, in FRAC_BITS fixed point.
    function automatic int scale_q(input int src, input int dst, input int frac);
        return ((src - 1) << frac) / (dst - 1);
    endfunction

endpackage

// File: rtl/dsa_pixel_engine_if.sv
// Memory port of the pixel engine: synchronous source reads and
// destination writes on one shared address space.
interface dsa_pixel_engine_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/dsa_bilinear_core.sv
// Combinational 2-D lerp of four neighbours with round-half-up and
// saturation; wide enough that no intermediate product is truncated.
module dsa_bilinear_core #(
    parameter int PIX_W     = 8,
    parameter int FRAC_BITS = 8
) (
    input  logic [PIX_W-1:0]     i00,
    input  logic [PIX_W-1:0]     i10,
    input  logic [PIX_W-1:0]     i01,
    input  logic [PIX_W-1:0]     i11,
    input  logic [FRAC_BITS-1:0] fx,
    input  logic [FRAC_BITS-1:0] fy,
    output logic [PIX_W-1:0]     res
);
    localparam int ACC_W = PIX_W + 2*FRAC_BITS + 2;
    localparam logic [ACC_W-1:0] ONE     = ACC_W'(1) << FRAC_BITS;
    localparam logic [ACC_W-1:0] HALF    = ACC_W'(1) << (2*FRAC_BITS - 1);
    localparam logic [ACC_W-1:0] MAX_PIX = (ACC_W'(1) << PIX_W) - ACC_W'(1);

    logic [ACC_W-1:0] wx, wy, top, bot, acc, scaled;

    always_comb begin
        wx     = ACC_W'(fx);
        wy     = ACC_W'(fy);
        top    = ACC_W'(i00) * (ONE - wx) + ACC_W'(i10) * wx;
        bot    = ACC_W'(i01) * (ONE - wx) + ACC_W'(i11) * wx;
        acc    = top * (ONE - wy) + bot * wy + HALF;
        scaled = acc >> (2*FRAC_BITS);
        res    = (scaled > MAX_PIX) ? MAX_PIX[PIX_W-1:0] : scaled[PIX_W-1:0];
    end
endmodule

// File: rtl/dsa_pixel_engine.sv
// Per-pixel bilinear upscaler: maps a destination index to source
// coordinates, reads four neighbours, interpolates and writes one pixel.
module dsa_pixel_engine
    import dsa_pkg::*;
#(
    parameter int SRC_WIDTH  = 4,
    parameter int SRC_HEIGHT = 4,
    parameter int DST_WIDTH  = 8,
    parameter int DST_HEIGHT = 8,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int ADDR_W     = 16,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_pixel,
    input  logic [15:0] pixel_index,
    output logic        done_pixel,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_range,
    dsa_pixel_engine_if.master mem
);
    localparam int XW   = $clog2(DST_WIDTH);
    localparam int SX   = scale_q(SRC_WIDTH, DST_WIDTH, FRAC_BITS);
    localparam int SY   = scale_q(SRC_HEIGHT, DST_HEIGHT, FRAC_BITS);
    localparam int XS_W = COORD_W + FRAC_BITS;
    localparam int NPIX = DST_WIDTH * DST_HEIGHT;

    state_t            state, state_nxt;
    logic [15:0]       idx_q;
    coord_t            crd, calc_crd;
    logic              range_bad, range_now, accept;
    logic [PIX_W-1:0]  pix00, pix10, pix01, pix11, res_q, core_res;
    logic [XS_W-1:0]   xs, ys;
    logic [COORD_W:0]  x0n, y0n;
    logic [COORD_W-1:0] rx, ry;
    logic              rd_en, wr_en;

    // Source coordinates and fractional weights of the latched destination index.
    always_comb begin
        xs            = XS_W'(idx_q[XW-1:0]) * XS_W'(SX);
        ys            = XS_W'(idx_q >> XW) * XS_W'(SY);
        calc_crd      = '0;
        calc_crd.x0   = xs[XS_W-1:FRAC_BITS];
        calc_crd.y0   = ys[XS_W-1:FRAC_BITS];
        calc_crd.fx   = xs[FRAC_BITS-1:0];
        calc_crd.fy   = ys[FRAC_BITS-1:0];
        x0n           = {1'b0, calc_crd.x0} + (COORD_W+1)'(1);
        y0n           = {1'b0, calc_crd.y0} + (COORD_W+1)'(1);
        calc_crd.x1   = (x0n > (COORD_W+1)'(SRC_WIDTH - 1)) ? COORD_W'(SRC_WIDTH - 1) : x0n[COORD_W-1:0];
        calc_crd.y1   = (y0n > (COORD_W+1)'(SRC_HEIGHT - 1)) ? COORD_W'(SRC_HEIGHT - 1) : y0n[COORD_W-1:0];
        range_now     = {16'b0, idx_q} >= 32'(NPIX);
    end

    always_comb begin
        accept    = next_pixel && (state == S_IDLE || state == S_WRITE);
        state_nxt = state;
        case (state)
            S_IDLE:   if (next_pixel) state_nxt = S_CALC;
            S_CALC:   state_nxt = range_now ? S_WRITE : S_RD00;
            S_RD00:   state_nxt = S_RD10;
            S_RD10:   state_nxt = S_RD01;
            S_RD01:   state_nxt = S_RD11;
            S_RD11:   state_nxt = S_WAIT;
            S_WAIT:   state_nxt = S_INTERP;
            S_INTERP: state_nxt = S_WRITE;
            S_WRITE:  state_nxt = next_pixel ? S_CALC : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        rx    = crd.x0;
        ry    = crd.y0;
        case (state)
            S_RD00: rd_en = 1'b1;
            S_RD10: begin rd_en = 1'b1; rx = crd.x1; end
            S_RD01: begin rd_en = 1'b1; ry = crd.y1; end
            S_RD11: begin rd_en = 1'b1; rx = crd.x1; ry = crd.y1; end
            default: ;
        endcase
    end

    // Address and data buses are held at zero whenever their strobe is low.
    assign wr_en        = (state == S_WRITE) && !range_bad;
    assign mem.rd_en    = rd_en;
    assign mem.rd_addr  = rd_en ? ADDR_W'(SRC_BASE) + ADDR_W'(ry) * ADDR_W'(SRC_WIDTH) + ADDR_W'(rx) : '0;
    assign mem.wr_en    = wr_en;
    assign mem.wr_addr  = wr_en ? ADDR_W'(DST_BASE) + ADDR_W'(idx_q) : '0;
    assign mem.wr_data  = wr_en ? res_q : '0;
    assign done_pixel   = (state == S_WRITE);
    assign busy         = (state != S_IDLE);

    dsa_bilinear_core #(.PIX_W(PIX_W), .FRAC_BITS(FRAC_BITS)) u_core (
        .i00(pix00), .i10(pix10), .i01(pix01), .i11(pix11),
        .fx(crd.fx), .fy(crd.fy), .res(core_res)
    );

    // Each neighbour is captured one state after its read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx_q       <= '0;
            crd         <= '0;
            range_bad   <= 1'b0;
            pix00       <= '0;
            pix10       <= '0;
            pix01       <= '0;
            pix11       <= '0;
            res_q       <= '0;
            err_overrun <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) idx_q <= pixel_index;
            if (next_pixel && !accept) err_overrun <= 1'b1;
            case (state)
                S_CALC: begin
                    crd       <= calc_crd;
                    range_bad <= range_now;
                    if (range_now) err_range <= 1'b1;
                end
                S_RD10:   pix00 <= mem.rd_data;
                S_RD01:   pix10 <= mem.rd_data;
                S_RD11:   pix01 <= mem.rd_data;
                S_WAIT:   pix11 <= mem.rd_data;
                S_INTERP: res_q <= core_res;
                default: ;
            endcase
        end
    end
endmodule
